sha3_digest_streamer: RTL and testbench

Parametrised output stage of the SHA-3 core. It captures the final 1600-bit Keccak state and emits it as an AXI4-Stream master. The output is either the truncated digest (SHA3-224/256/384/512) or the full state. The block supports TREADY backpressure, TKEEP on a partial final beat, optional byte reversal, and zero-bubble back-to-back loads. It sits between the permutation core and the AXI output port.

---
 rtl/sha3_pkg.sv | 32 +++
 rtl/sha3_digest_streamer.sv | 93 +++++++++
 tb/tb_sha3_digest_streamer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared SHA-3 output-stage types, sizes and mode helpers
package sha3_pkg;
    localparam int LANE_W  = 64;
    localparam int STATE_W = 1600;

    typedef enum logic [2:0] {
        M224  = 3'd0,
        M256  = 3'd1,
        M384  = 3'd2,
        M512  = 3'd3,
        MFULL = 3'd4
    } sha3_mode_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } strm_state_e;

    // Unassigned codes 5-7 fall through to the SHA3-256 length.
    function automatic int mode_bits(input logic [2:0] mode);
        return (mode == M224) ? 224 : (mode == M384) ? 384 : (mode == M512) ? 512 :
               (mode == MFULL) ? 1600 : 256;
    endfunction

    function automatic int mode_beats(input logic [2:0] mode, input int dw);
        return (mode_bits(mode) + dw - 1) / dw;
    endfunction

    function automatic int last_keep_bytes(input logic [2:0] mode, input int dw);
        return mode_bits(mode) / 8 - (mode_beats(mode, dw) - 1) * (dw / 8);
    endfunction
endpackage

// File: rtl/sha3_digest_streamer.sv
// sha3_digest_streamer: streams a captured Keccak state as an AXI4-Stream digest
module sha3_digest_streamer
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter bit BYTE_REVERSE = 1'b0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [4:0][4:0][63:0]   state_i,
    input  logic [2:0]              mode_i,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TLAST,
    output logic [2:0]              M_AXIS_TUSER
);
    localparam int NB = DATA_WIDTH / 8;

    if (!(DATA_WIDTH inside {8, 16, 32, 64})) begin : g_bad_dw
        $error("sha3_digest_streamer: DATA_WIDTH must be 8, 16, 32 or 64");
    end

    strm_state_e           state_q, state_d;
    logic [STATE_W-1:0]    sr_q, sr_d, packed_state;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            mode_q, mode_d, tuser_q, tuser_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [NB-1:0]         tkeep_q, tkeep_d, keep_nat;
    logic                  tlast_q, tlast_d, beat_hs, load_fire, stream_d, beat_last;

    // Lane k = x + 5y sits at bits [64k +: 64], so beat i is simply the low word after i shifts.
    for (genvar x = 0; x < 5; x++) begin : g_x
        for (genvar y = 0; y < 5; y++) begin : g_y
            assign packed_state[(x + 5 * y) * LANE_W +: LANE_W] = state_i[x][y];
        end
    end

    assign beat_hs    = (state_q == S_STREAM) && M_AXIS_TREADY;
    assign load_ready = (state_q == S_IDLE) || (beat_hs && tlast_q);
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            tdata_q <= '0;
            tkeep_q <= '0;
            tlast_q <= 1'b0;
            tuser_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tdata_q <= tdata_d;
            tkeep_q <= tkeep_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
        end
    end

    always_comb state_d = load_fire ? S_STREAM : (beat_hs && tlast_q) ? S_IDLE : state_q;

    // Outputs are registered: each is computed from the state the next cycle will hold.
    always_comb begin
        sr_d      = load_fire ? packed_state : beat_hs ? sr_q >> DATA_WIDTH : sr_q;
        cnt_d     = load_fire ? 8'd0 : beat_hs ? cnt_q + 8'd1 : cnt_q;
        mode_d    = load_fire ? mode_i : mode_q;
        stream_d  = state_d == S_STREAM;
        beat_last = cnt_d == 8'(mode_beats(mode_d, DATA_WIDTH) - 1);
        keep_nat  = beat_last ? NB'((1 << last_keep_bytes(mode_d, DATA_WIDTH)) - 1) : '1;
        tdata_d   = '0;
        tkeep_d   = '0;
        for (int j = 0; j < NB; j++) begin
            tdata_d[8 * (BYTE_REVERSE ? NB - 1 - j : j) +: 8] = (stream_d && keep_nat[j]) ? sr_d[8 * j +: 8] : 8'h00;
            tkeep_d[BYTE_REVERSE ? NB - 1 - j : j] = stream_d && keep_nat[j];
        end
        tlast_d   = stream_d && beat_last;
        tuser_d   = stream_d ? mode_d : 3'd0;
    end

    assign M_AXIS_TVALID = state_q == S_STREAM;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TKEEP  = tkeep_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TUSER  = tuser_q;
endmodule

// File: tb/tb_sha3_digest_streamer.sv
// tb_sha3_digest_streamer: byte-level reference model checked against five width/reversal configurations
module tb_sha3_digest_streamer;
    typedef logic [24:0][63:0] lanes_t;
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int ln, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane=%0d got=%h want=%h t=%0t", nm, ln, act, exp, $time);
        end
    endtask

    function automatic int mbits(input logic [2:0] m);
        case (m)
            3'd0: return 224;
            3'd2: return 384;
            3'd3: return 512;
            3'd4: return 1600;
            default: return 256;
        endcase
    endfunction

    function automatic int nbeats(input int dw, input logic [2:0] m);
        return (mbits(m) + dw - 1) / dw;
    endfunction

    // Digest byte b is byte (b % 8) of lane b / 8; a word slot holds it only while b is inside the digest.
    function automatic beat_t exp_beat(input int dw, input bit rev, input lanes_t ln, input logic [2:0] m, input int beat);
        beat_t r;
        int b, p;
        r = '0;
        for (int j = 0; j < dw / 8; j++) begin
            b = beat * (dw / 8) + j;
            p = rev ? dw / 8 - 1 - j : j;
            if (b < mbits(m) / 8) begin
                r.d[8 * p +: 8] = ln[b / 8][8 * (b % 8) +: 8];
                r.k[p] = 1'b1;
            end
        end
        r.last = beat == nbeats(dw, m) - 1;
        return r;
    endfunction

    function automatic lanes_t pat_lanes();
        lanes_t r;
        for (int k = 0; k < 25; k++) r[k] = {8{8'(k)}};
        return r;
    endfunction

    function automatic lanes_t rnd_lanes();
        lanes_t r;
        for (int k = 0; k < 25; k++) r[k] = {$urandom, $urandom};
        return r;
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int DW  = 8 << (g % 4);
        localparam bit REV = (g == 4);

        logic                  rst, ldv, trdy, ready, tvalid, tlast;
        logic [2:0]            mode, tuser;
        logic [DW-1:0]         tdata;
        logic [DW/8-1:0]       tkeep;
        lanes_t                lanes, m_lanes;
        logic [4:0][4:0][63:0] st;
        bit                    m_act, en;
        bit [2:0]              m_mode;
        int                    m_beat;
        logic                  m_last, m_rdy;
        beat_t                 eb;

        always_comb
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) st[x][y] = lanes[x + 5 * y];

        sha3_digest_streamer #(.DATA_WIDTH(DW), .BYTE_REVERSE(REV)) u_dut (
            .ACLK(clk), .ARESET(rst), .state_i(st), .mode_i(mode),
            .load_valid(ldv), .load_ready(ready),
            .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TVALID(tvalid),
            .M_AXIS_TREADY(trdy), .M_AXIS_TLAST(tlast), .M_AXIS_TUSER(tuser)
        );

        assign m_last = m_act && (m_beat == nbeats(DW, m_mode) - 1);
        assign m_rdy  = !m_act || (trdy && m_last);
        assign eb     = exp_beat(DW, REV, m_lanes, m_mode, m_beat);

        always @(posedge clk)
            if (rst) begin
                m_act  <= 1'b0;
                m_beat <= 0;
            end else if (ldv && m_rdy) begin
                m_act   <= 1'b1;
                m_beat  <= 0;
                m_mode  <= mode;
                m_lanes <= lanes;
            end else if (m_act && trdy) begin
                m_act  <= !m_last;
                m_beat <= m_beat + 1;
            end

        always @(negedge clk)
            if (en) begin
                chk("load_ready", g, 64'(ready), 64'(m_rdy));
                chk("tvalid", g, 64'(tvalid), 64'(m_act));
                if (m_act) begin
                    chk("tdata", g, 64'(tdata), eb.d);
                    chk("tkeep", g, 64'(tkeep), 64'(eb.k));
                    chk("tlast", g, 64'(tlast), 64'(eb.last));
                    chk("tuser", g, 64'(tuser), 64'(m_mode));
                end
            end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic load(input logic [2:0] m, input lanes_t l);
            ldv = 1'b1;
            mode = m;
            lanes = l;
            step();
            ldv = 1'b0;
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 1000 && m_act; i++) step();
            chk("idle_wait", g, 64'(m_act), 64'd0);
        endtask

        initial begin : drv
            int n;
            rst = 1'b1; ldv = 1'b0; trdy = 1'b1; mode = 3'd0; lanes = pat_lanes();
            step();
            step();
            rst = 1'b0;
            @(negedge clk);
            en = 1'b1;
            chk("rst_tvalid", g, 64'(tvalid), 64'd0);
            chk("rst_tdata", g, 64'(tdata), 64'd0);
            chk("rst_tkeep", g, 64'(tkeep), 64'd0);
            chk("rst_tlast", g, 64'(tlast), 64'd0);
            chk("rst_tuser", g, 64'(tuser), 64'd0);
            chk("rst_ready", g, 64'(ready), 64'd1);
            step();
            load(3'd1, pat_lanes());
            wait_idle();
            load(3'd0, pat_lanes());
            wait_idle();
            load(3'd4, pat_lanes());
            wait_idle();
            // Stall beat 2 for three cycles; the packet must stretch by exactly that much.
            load(3'd1, pat_lanes());
            n = 0;
            for (int c = 0; c < 400 && m_act; c++) begin
                trdy = !(c >= 2 && c < 5);
                @(negedge clk);
                n += int'(tvalid);
                step();
            end
            trdy = 1'b1;
            chk("bp_cycles", g, 64'(n), 64'(nbeats(DW, 3'd1) + 3));
            load(3'd1, pat_lanes());
            for (int i = 0; i < 300 && !m_last; i++) step();
            load(3'd3, rnd_lanes());
            @(negedge clk);
            chk("b2b_tvalid", g, 64'(tvalid), 64'd1);
            chk("b2b_tuser", g, 64'(tuser), 64'd3);
            step();
            wait_idle();
            load(3'd4, pat_lanes());
            for (int i = 0; i < 300 && m_beat != 4; i++) step();
            rst = 1'b1;
            ldv = 1'b1;
            step();
            rst = 1'b0;
            ldv = 1'b0;
            @(negedge clk);
            chk("midrst_tvalid", g, 64'(tvalid), 64'd0);
            chk("midrst_tlast", g, 64'(tlast), 64'd0);
            chk("midrst_ready", g, 64'(ready), 64'd1);
            step();
            rst = 1'b1;
            ldv = 1'b1;
            step();
            rst = 1'b0;
            ldv = 1'b0;
            @(negedge clk);
            chk("rst_over_load", g, 64'(tvalid), 64'd0);
            step();
            load(3'd2, pat_lanes());
            wait_idle();
            for (int c = 0; c < 1500; c++) begin
                rst   = $urandom_range(0, 399) == 0;
                ldv   = $urandom_range(0, 1) == 1;
                trdy  = $urandom_range(0, 9) < 7;
                mode  = 3'($urandom_range(0, 7));
                lanes = rnd_lanes();
                step();
            end
            rst = 1'b0;
            ldv = 1'b0;
            trdy = 1'b1;
            wait_idle();
            n_done++;
        end
    end

    initial begin : main
        beat_t  b;
        lanes_t rl;
        logic [31:0] lit [8] = '{32'h00000000, 32'h00000000, 32'h01010101, 32'h01010101,
                                 32'h02020202, 32'h02020202, 32'h03030303, 32'h03030303};
        for (int i = 0; i < 8; i++) begin
            b = exp_beat(32, 1'b0, pat_lanes(), 3'd1, i);
            chk("pin32_data", i, b.d, 64'(lit[i]));
            chk("pin32_keep", i, 64'(b.k), 64'h0F);
            chk("pin32_last", i, 64'(b.last), 64'(i == 7));
        end
        b = exp_beat(64, 1'b0, pat_lanes(), 3'd0, 3);
        chk("pin64_data", 3, b.d, 64'h0000000003030303);
        chk("pin64_keep", 3, 64'(b.k), 64'h0F);
        chk("pin64_last", 3, 64'(b.last), 64'd1);
        b = exp_beat(16, 1'b0, pat_lanes(), 3'd4, 99);
        chk("pin16_data", 99, b.d, 64'h1818);
        chk("pin16_last", 99, 64'(b.last), 64'd1);
        b = exp_beat(16, 1'b0, pat_lanes(), 3'd4, 98);
        chk("pin16_notlast", 98, 64'(b.last), 64'd0);
        rl = pat_lanes();
        rl[0] = 64'h0706050403020100;
        b = exp_beat(32, 1'b1, rl, 3'd0, 0);
        chk("pinrev_data0", 0, b.d, 64'h00010203);
        b = exp_beat(32, 1'b1, rl, 3'd0, 1);
        chk("pinrev_data1", 1, b.d, 64'h04050607);
        b = exp_beat(64, 1'b1, pat_lanes(), 3'd0, 3);
        chk("pinrev_keep", 3, 64'(b.k), 64'hF0);
        for (int c = 0; c < 20000 && n_done < 5; c++) @(posedge clk);
        chk("lanes_done", -1, 64'(n_done), 64'd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
